hazard_detection_unit: RTL and testbench

Stall/flush controller for the 5-stage pipeline. It is the producer side of hazard resolution: the forwarding unit resolves hazards by bypassing data, and this block resolves the hazards that bypassing cannot fix. It detects load-use hazards in decode, taken-branch flushes in execute, and multi-cycle data-memory accesses in MEM. From these it drives the write-enable and flush controls of PC, IF/DEC, DEC/EX, EX/MEM and MEM/WB, and keeps saturating stall and flush counters for performance readout.

---
 rtl/hazard_detection_unit_pkg.sv | 26 ++
 rtl/hazard_detection_unit_perf_counter.sv | 23 ++
 rtl/hazard_detection_unit.sv | 126 ++++++++++++
 tb/tb_hazard_detection_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the hazard detection unit: FSM state encoding,
// register-address width, the x0 constant and small sizing/matching helpers.
package hazard_detection_unit_pkg;

  localparam int REG_AD_W = 5;
  localparam logic [REG_AD_W-1:0] REG_X0 = '0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hdu_state_e;

  // Wait counter must hold WAIT_MAX itself, never narrower than 4 bits.
  function automatic int wait_cnt_w(input int wait_max);
    int w;
    w = $clog2(wait_max + 1);
    return (w < 4) ? 4 : w;
  endfunction

  function automatic logic src_match(input logic                used,
                                     input logic [REG_AD_W-1:0] rs,
                                     input logic [REG_AD_W-1:0] rd);
    return used && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_detection_unit_perf_counter.sv
// Saturating up-counter with increment enable, used for stall/flush statistics.
module hazard_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc_en_i && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Stall/flush controller: load-use stalls, taken-branch flushes and data-memory
// wait freezes for the 5-stage pipeline, plus saturating performance counters.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AD_W-1:0] if_dec_rs1_ad,
  input  logic [REG_AD_W-1:0] if_dec_rs2_ad,
  input  logic                if_dec_rs1_used,
  input  logic                if_dec_rs2_used,
  input  logic                if_dec_DMwriteEn,
  input  logic [REG_AD_W-1:0] dec_ex_rd_ad,
  input  logic                dec_ex_DMread,
  input  logic                ex_branch_taken,
  input  logic                ex_mem_DMread,
  input  logic                ex_mem_DMwriteEn,
  input  logic                dm_ack,
  output logic                pc_writeEn,
  output logic                if_dec_writeEn,
  output logic                dec_ex_writeEn,
  output logic                ex_mem_writeEn,
  output logic                if_dec_flush,
  output logic                dec_ex_flush,
  output logic                mem_wb_flush,
  output logic                dm_timeout,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam int                WAIT_W     = wait_cnt_w(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

  hdu_state_e        state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              timeout_q;

  logic dm_req;
  logic timeout_hit;
  logic freeze;
  logic load_use;
  logic freeze_apply;
  logic branch_apply;
  logic load_stall;

  always_comb begin
    dm_req      = ex_mem_DMread || ex_mem_DMwriteEn;
    timeout_hit = (state_q == ST_MEM_WAIT) && !dm_ack && (wait_q == WAIT_LIMIT);
    // The timeout cycle releases the freeze so the pipeline can move on.
    freeze      = ((state_q == ST_RUN) && dm_req && !dm_ack) ||
                  ((state_q == ST_MEM_WAIT) && !dm_ack && !timeout_hit);

    // A store's rs2 is covered by the load-to-store data forward.
    load_use    = dec_ex_DMread && (dec_ex_rd_ad != REG_X0) &&
                  (src_match(if_dec_rs1_used, if_dec_rs1_ad, dec_ex_rd_ad) ||
                   (src_match(if_dec_rs2_used, if_dec_rs2_ad, dec_ex_rd_ad) &&
                    !if_dec_DMwriteEn));

    freeze_apply = !rst && freeze;
    branch_apply = !rst && !freeze && ex_branch_taken;
    load_stall   = !rst && !freeze && !ex_branch_taken && load_use;
  end

  always_comb begin
    pc_writeEn     = !(freeze_apply || load_stall);
    if_dec_writeEn = !(freeze_apply || load_stall);
    dec_ex_writeEn = !freeze_apply;
    ex_mem_writeEn = !freeze_apply;
    if_dec_flush   = branch_apply;
    dec_ex_flush   = branch_apply || load_stall;
    mem_wb_flush   = freeze_apply;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (dm_req && !dm_ack) begin
            state_q <= ST_MEM_WAIT;
            wait_q  <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (dm_ack) begin
            state_q <= ST_RUN;
            wait_q  <= '0;
          end else if (timeout_hit) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        default: begin
          state_q <= ST_RUN;
          wait_q  <= '0;
        end
      endcase
    end
  end

  assign dm_timeout = timeout_q;

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (freeze_apply || load_stall),
    .count_o  (stall_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (branch_apply),
    .count_o  (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios plus a
// randomized run against an elapsed-cycle reference model.
module tb_hazard_detection_unit;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam logic [6:0] C_NORMAL = 7'b1111_000;
  localparam logic [6:0] C_LOAD   = 7'b0011_010;
  localparam logic [6:0] C_BRANCH = 7'b1111_110;
  localparam logic [6:0] C_FREEZE = 7'b0000_001;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       if_dec_rs1_ad, if_dec_rs2_ad, dec_ex_rd_ad;
  logic             if_dec_rs1_used, if_dec_rs2_used, if_dec_DMwriteEn;
  logic             dec_ex_DMread, ex_branch_taken;
  logic             ex_mem_DMread, ex_mem_DMwriteEn, dm_ack;
  logic             pc_writeEn, if_dec_writeEn, dec_ex_writeEn, ex_mem_writeEn;
  logic             if_dec_flush, dec_ex_flush, mem_wb_flush, dm_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0]       ctl;

  int checks = 0;
  int errors = 0;

  // Reference model state: outstanding access and its age in cycles.
  bit m_busy;
  int m_elapsed;
  bit m_timeout;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  assign ctl = {pc_writeEn, if_dec_writeEn, dec_ex_writeEn, ex_mem_writeEn,
                if_dec_flush, dec_ex_flush, mem_wb_flush};

  hazard_detection_unit #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_dec_rs1_ad    (if_dec_rs1_ad),
    .if_dec_rs2_ad    (if_dec_rs2_ad),
    .if_dec_rs1_used  (if_dec_rs1_used),
    .if_dec_rs2_used  (if_dec_rs2_used),
    .if_dec_DMwriteEn (if_dec_DMwriteEn),
    .dec_ex_rd_ad     (dec_ex_rd_ad),
    .dec_ex_DMread    (dec_ex_DMread),
    .ex_branch_taken  (ex_branch_taken),
    .ex_mem_DMread    (ex_mem_DMread),
    .ex_mem_DMwriteEn (ex_mem_DMwriteEn),
    .dm_ack           (dm_ack),
    .pc_writeEn       (pc_writeEn),
    .if_dec_writeEn   (if_dec_writeEn),
    .dec_ex_writeEn   (dec_ex_writeEn),
    .ex_mem_writeEn   (ex_mem_writeEn),
    .if_dec_flush     (if_dec_flush),
    .dec_ex_flush     (dec_ex_flush),
    .mem_wb_flush     (mem_wb_flush),
    .dm_timeout       (dm_timeout),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt)
  );

  task automatic clear_inputs();
    if_dec_rs1_ad    = 5'd0;
    if_dec_rs2_ad    = 5'd0;
    if_dec_rs1_used  = 1'b0;
    if_dec_rs2_used  = 1'b0;
    if_dec_DMwriteEn = 1'b0;
    dec_ex_rd_ad     = 5'd0;
    dec_ex_DMread    = 1'b0;
    ex_branch_taken  = 1'b0;
    ex_mem_DMread    = 1'b0;
    ex_mem_DMwriteEn = 1'b0;
    dm_ack           = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    m_busy    = 0;
    m_elapsed = 0;
    m_timeout = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // Expected outputs for the present cycle, then advance past the next edge.
  task automatic model_cycle(output logic [6:0] e_ctl, output logic e_tmo,
                             output int e_stall, output int e_flush);
    bit active, frz, tmo_hit, lu;
    int age;
    e_tmo   = m_timeout;
    e_stall = m_stall;
    e_flush = m_flush;
    active  = m_busy || ex_mem_DMread || ex_mem_DMwriteEn;
    frz     = 0;
    tmo_hit = 0;
    age     = m_busy ? m_elapsed : 0;
    if (active && !dm_ack) begin
      if (age == WAIT_MAX + 1) tmo_hit = 1;
      else frz = 1;
    end
    if (!active || dm_ack || tmo_hit) begin
      m_busy = 0; m_elapsed = 0;
    end else begin
      m_busy = 1; m_elapsed = age + 1;
    end
    if (tmo_hit) m_timeout = 1;
    lu = dec_ex_DMread && (dec_ex_rd_ad != 5'd0) &&
         ((if_dec_rs1_used && if_dec_rs1_ad == dec_ex_rd_ad) ||
          (if_dec_rs2_used && !if_dec_DMwriteEn && if_dec_rs2_ad == dec_ex_rd_ad));
    if (frz)                  e_ctl = C_FREEZE;
    else if (ex_branch_taken) e_ctl = C_BRANCH;
    else if (lu)              e_ctl = C_LOAD;
    else                      e_ctl = C_NORMAL;
    if (e_ctl[6:3] != 4'hF && m_stall < CNT_MAX) m_stall++;
    if (e_ctl == C_BRANCH && m_flush < CNT_MAX) m_flush++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    dec_ex_DMread = 1'b1; dec_ex_rd_ad = 5'd5; if_dec_rs1_ad = 5'd5; if_dec_rs1_used = 1'b1;
    ex_mem_DMread = 1'b1; ex_branch_taken = 1'b1;
    #2;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_NORMAL); end
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
    checks++; if (dm_timeout !== 1'b0) begin errors++; $display("FAIL reset_tmo: got %b expected 0", dm_timeout); end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    @(negedge clk); #2;
    checks++; if (ctl !== C_NORMAL || stall_cnt !== 0 || flush_cnt !== 0) begin errors++; $display("FAIL post_reset: got %b %0d %0d expected %b 0 0", ctl, stall_cnt, flush_cnt, C_NORMAL); end
  endtask

  task automatic test_load_use();
    do_reset();
    dec_ex_DMread = 1'b1; dec_ex_rd_ad = 5'd5; if_dec_rs1_ad = 5'd5; if_dec_rs1_used = 1'b1;
    #2;
    checks++; if (ctl !== C_LOAD) begin errors++; $display("FAIL load_use: got %b expected %b", ctl, C_LOAD); end
    @(negedge clk);
    dec_ex_DMread = 1'b0;
    #2;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL load_use_end: got %b expected %b", ctl, C_NORMAL); end
    checks++; if (stall_cnt !== 1) begin errors++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
  endtask

  task automatic test_store_and_x0();
    do_reset();
    dec_ex_DMread = 1'b1; dec_ex_rd_ad = 5'd5;
    if_dec_DMwriteEn = 1'b1; if_dec_rs2_ad = 5'd5; if_dec_rs2_used = 1'b1;
    if_dec_rs1_ad = 5'd3; if_dec_rs1_used = 1'b1;
    #2;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL store_rs2: got %b expected %b", ctl, C_NORMAL); end
    @(negedge clk);
    if_dec_rs1_ad = 5'd5;
    #2;
    checks++; if (ctl !== C_LOAD) begin errors++; $display("FAIL store_rs1: got %b expected %b", ctl, C_LOAD); end
    @(negedge clk);
    clear_inputs();
    dec_ex_DMread = 1'b1; dec_ex_rd_ad = 5'd0;
    if_dec_rs1_used = 1'b1; if_dec_rs2_used = 1'b1;
    #2;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL x0_load: got %b expected %b", ctl, C_NORMAL); end
  endtask

  task automatic test_branch_priority();
    do_reset();
    dec_ex_DMread = 1'b1; dec_ex_rd_ad = 5'd7; if_dec_rs2_ad = 5'd7; if_dec_rs2_used = 1'b1;
    ex_branch_taken = 1'b1;
    #2;
    checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL branch_over_load: got %b expected %b", ctl, C_BRANCH); end
    @(negedge clk);
    clear_inputs();
    #2;
    checks++; if (flush_cnt !== 1 || stall_cnt !== 0) begin errors++; $display("FAIL branch_cnt: got %0d/%0d expected 1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    ex_mem_DMread = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      dm_ack = (i == 4);
      #2;
      checks++;
      if (ctl !== ((i == 4) ? C_BRANCH : C_FREEZE)) begin
        errors++; $display("FAIL mem_wait_c%0d: got %b expected %b", i, ctl, (i == 4) ? C_BRANCH : C_FREEZE);
      end
      @(negedge clk);
    end
    clear_inputs();
    #2;
    checks++; if (stall_cnt !== 3 || ctl !== C_NORMAL) begin errors++; $display("FAIL mem_wait_cnt: got %0d %b expected 3 %b", stall_cnt, ctl, C_NORMAL); end
    do_reset();
    ex_mem_DMwriteEn = 1'b1; dm_ack = 1'b1;
    repeat (4) @(negedge clk);
    clear_inputs();
    #2;
    checks++; if (stall_cnt !== 0 || ctl !== C_NORMAL) begin errors++; $display("FAIL zero_wait: got %0d %b expected 0 %b", stall_cnt, ctl, C_NORMAL); end
  endtask

  task automatic test_timeout();
    int nfrz;
    bit done;
    do_reset();
    nfrz = 0; done = 0;
    ex_mem_DMread = 1'b1;
    for (int i = 0; i < WAIT_MAX + 8; i++) begin
      #2;
      if (ctl === C_FREEZE) nfrz++;
      else begin done = 1; break; end
      @(negedge clk);
    end
    checks++; if (!done || nfrz != WAIT_MAX + 1) begin errors++; $display("FAIL timeout_len: got %0d freeze cycles (released=%0d) expected %0d", nfrz, done, WAIT_MAX + 1); end
    checks++; if (dm_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b expected 0", dm_timeout); end
    @(negedge clk);
    ex_mem_DMread = 1'b0;
    #2;
    checks++; if (dm_timeout !== 1'b1 || ctl !== C_NORMAL) begin errors++; $display("FAIL timeout_set: got %b %b expected 1 %b", dm_timeout, ctl, C_NORMAL); end
    repeat (5) @(negedge clk);
    #2;
    checks++; if (dm_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", dm_timeout); end
    // Reset in the middle of a wait, away from any clock edge.
    @(negedge clk);
    ex_mem_DMread = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL mid_wait: got %b expected %b", ctl, C_FREEZE); end
    #1 rst = 1'b1;
    #1;
    checks++; if (ctl !== C_NORMAL || stall_cnt !== 0 || dm_timeout !== 1'b0) begin errors++; $display("FAIL async_reset: got %b %0d %b expected %b 0 0", ctl, stall_cnt, dm_timeout, C_NORMAL); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #2;
    checks++; if (ctl !== C_NORMAL) begin errors++; $display("FAIL reset_to_run: got %b expected %b", ctl, C_NORMAL); end
  endtask

  task automatic test_saturation();
    do_reset();
    dec_ex_DMread = 1'b1; dec_ex_rd_ad = 5'd9; if_dec_rs1_ad = 5'd9; if_dec_rs1_used = 1'b1;
    repeat (CNT_MAX + 40) @(negedge clk);
    clear_inputs();
    #2;
    checks++; if (stall_cnt !== CNT_W'(CNT_MAX)) begin errors++; $display("FAIL stall_saturate: got %0d expected %0d", stall_cnt, CNT_MAX); end
  endtask

  task automatic test_random();
    logic [6:0] e_ctl;
    logic       e_tmo;
    int         e_stall, e_flush;
    bit         slow;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      slow = ((cyc / 400) % 3) == 2;
      if_dec_rs1_ad    = 5'($urandom_range(0, 3));
      if_dec_rs2_ad    = 5'($urandom_range(0, 3));
      dec_ex_rd_ad     = 5'($urandom_range(0, 3));
      if_dec_rs1_used  = 1'($urandom);
      if_dec_rs2_used  = 1'($urandom);
      if_dec_DMwriteEn = 1'($urandom);
      dec_ex_DMread    = 1'($urandom);
      ex_branch_taken  = ($urandom_range(0, 5) == 0);
      ex_mem_DMread    = ($urandom_range(0, 3) == 0);
      ex_mem_DMwriteEn = ($urandom_range(0, 5) == 0);
      dm_ack           = slow ? ($urandom_range(0, 40) == 0) : 1'($urandom);
      #2;
      model_cycle(e_ctl, e_tmo, e_stall, e_flush);
      checks++; if (ctl !== e_ctl) begin errors++; $display("FAIL rand_ctl @%0d: got %b expected %b", cyc, ctl, e_ctl); end
      checks++; if (dm_timeout !== e_tmo) begin errors++; $display("FAIL rand_tmo @%0d: got %b expected %b", cyc, dm_timeout, e_tmo); end
      checks++; if (stall_cnt !== CNT_W'(e_stall)) begin errors++; $display("FAIL rand_stall @%0d: got %0d expected %0d", cyc, stall_cnt, e_stall); end
      checks++; if (flush_cnt !== CNT_W'(e_flush)) begin errors++; $display("FAIL rand_flush @%0d: got %0d expected %0d", cyc, flush_cnt, e_flush); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_store_and_x0();
    test_branch_priority();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
